// File: rtl/axis_header_insert_arbiter_if.sv
// Bundle between N header/payload requesters, the arbiter and the downstream insert engine.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface axis_header_insert_arbiter_if #(
  parameter int N_REQ        = 2,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int GNT_WD       = $clog2(N_REQ)
);
  logic [N_REQ-1:0]              s_valid_in;
  logic [N_REQ*DATA_WD-1:0]      s_data_in;
  logic [N_REQ*DATA_BYTE_WD-1:0] s_keep_in;
  logic [N_REQ-1:0]              s_last_in;
  logic [N_REQ-1:0]              s_ready_in;
  logic [N_REQ-1:0]              s_valid_insert;
  logic [N_REQ*DATA_WD-1:0]      s_data_insert;
  logic [N_REQ*DATA_BYTE_WD-1:0] s_keep_insert;
  logic [N_REQ*BYTE_CNT_WD-1:0]  s_byte_insert_cnt;
  logic [N_REQ-1:0]              s_ready_insert;

  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;
  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
  logic                    ready_insert;

  logic [GNT_WD-1:0] gnt_id;
  logic              busy;
  logic              len_err;

  modport slave (
    input  s_valid_in, s_data_in, s_keep_in, s_last_in,
    output s_ready_in,
    input  s_valid_insert, s_data_insert, s_keep_insert, s_byte_insert_cnt,
    output s_ready_insert,
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    output valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_insert,
    output gnt_id, busy, len_err
  );

  modport master (
    output s_valid_in, s_data_in, s_keep_in, s_last_in,
    input  s_ready_in,
    output s_valid_insert, s_data_insert, s_keep_insert, s_byte_insert_cnt,
    input  s_ready_insert,
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_insert,
    input  gnt_id, busy, len_err
  );
endinterface

// File: rtl/axis_header_insert_arbiter.sv
// Round-robin arbiter locking one requester onto the insert engine for a whole packet
// (header, then payload through last); one idle arbitration cycle per packet, engine ready passed straight through.
module axis_header_insert_arbiter #(
  parameter int N_REQ        = 2,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int MAX_BEATS    = 64,
  parameter int GNT_WD       = $clog2(N_REQ)
) (
  input logic clk,
  input logic rst_n,
  axis_header_insert_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam int BEAT_WD = $clog2(MAX_BEATS + 1);

  logic [1:0]         state_q, state_d;
  logic [GNT_WD-1:0]  gnt_q, gnt_d;
  logic [GNT_WD-1:0]  rr_q, rr_d;
  logic [BEAT_WD-1:0] beat_q, beat_d;

  logic               pick_vld;
  logic [GNT_WD-1:0]  pick_idx;
  int                 idx;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!pick_vld && bus.s_valid_insert[GNT_WD'(idx)]) begin
        pick_vld = 1'b1;
        pick_idx = GNT_WD'(idx);
      end
    end
  end

  // Granted requester's fields; only registered gnt_q steers the muxes.
  logic                    g_vld_ins, g_vld_in, g_last_in;
  logic [DATA_WD-1:0]      g_dat_ins, g_dat_in;
  logic [DATA_BYTE_WD-1:0] g_keep_ins, g_keep_in;
  logic [BYTE_CNT_WD-1:0]  g_cnt_ins;

  assign g_vld_ins  = bus.s_valid_insert[gnt_q];
  assign g_dat_ins  = bus.s_data_insert[int'(gnt_q)*DATA_WD +: DATA_WD];
  assign g_keep_ins = bus.s_keep_insert[int'(gnt_q)*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign g_cnt_ins  = bus.s_byte_insert_cnt[int'(gnt_q)*BYTE_CNT_WD +: BYTE_CNT_WD];
  assign g_vld_in   = bus.s_valid_in[gnt_q];
  assign g_dat_in   = bus.s_data_in[int'(gnt_q)*DATA_WD +: DATA_WD];
  assign g_keep_in  = bus.s_keep_in[int'(gnt_q)*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign g_last_in  = bus.s_last_in[gnt_q];

  logic hdr_fire, beat_fire;
  assign hdr_fire  = (state_q == ST_HDR) && g_vld_ins && bus.ready_insert;
  assign beat_fire = (state_q == ST_BODY) && g_vld_in && bus.ready_in;

  always_comb begin
    bus.valid_insert    = 1'b0;
    bus.data_insert     = '0;
    bus.keep_insert     = '0;
    bus.byte_insert_cnt = '0;
    bus.s_ready_insert  = '0;
    bus.valid_in        = 1'b0;
    bus.data_in         = '0;
    bus.keep_in         = '0;
    bus.last_in         = 1'b0;
    bus.s_ready_in      = '0;
    case (state_q)
      ST_HDR: begin
        bus.valid_insert          = g_vld_ins;
        bus.data_insert           = g_dat_ins;
        bus.keep_insert           = g_keep_ins;
        bus.byte_insert_cnt       = g_cnt_ins;
        bus.s_ready_insert[gnt_q] = bus.ready_insert;
      end
      ST_BODY: begin
        bus.valid_in          = g_vld_in;
        bus.data_in           = g_dat_in;
        bus.keep_in           = g_keep_in;
        bus.last_in           = g_last_in;
        bus.s_ready_in[gnt_q] = bus.ready_in;
      end
      default: ;
    endcase
  end

  assign bus.gnt_id  = gnt_q;
  assign bus.busy    = (state_q != ST_IDLE);
  // The counter saturates at MAX_BEATS, so this equality can only hit once per packet.
  assign bus.len_err = beat_fire && (beat_q == BEAT_WD'(MAX_BEATS - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hdr_fire) state_d = ST_BODY;
      end
      ST_BODY: begin
        if (beat_fire) begin
          if (g_last_in) begin
            state_d = ST_IDLE;
            rr_d    = (int'(gnt_q) == N_REQ - 1) ? '0 : gnt_q + 1'b1;
            beat_d  = '0;
          end else if (beat_q < BEAT_WD'(MAX_BEATS)) begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_axis_header_insert_arbiter.sv
// Bench for axis_header_insert_arbiter: cycle vector table, hand-written corner sequences,
// and randomized multi-requester traffic checked against a packet-level round-robin model.
module tb_axis_header_insert_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 2;
  localparam int MB = 64;
  localparam int GW = 1;
  localparam int MAXP = 6;
  localparam int MAXL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_header_insert_arbiter_if #(.N_REQ(N), .DATA_WD(DW), .DATA_BYTE_WD(KW),
                                  .BYTE_CNT_WD(CW), .GNT_WD(GW)) bus ();

  axis_header_insert_arbiter #(.N_REQ(N), .DATA_WD(DW), .DATA_BYTE_WD(KW),
                               .BYTE_CNT_WD(CW), .MAX_BEATS(MB), .GNT_WD(GW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] ctrl();
    return {bus.busy, bus.gnt_id, bus.valid_insert, bus.valid_in, bus.last_in,
            bus.s_ready_insert, bus.s_ready_in, bus.len_err};
  endfunction

  task automatic zero_inputs();
    bus.s_valid_in = '0;        bus.s_data_in = '0;     bus.s_keep_in = '0;
    bus.s_last_in = '0;         bus.s_valid_insert = '0; bus.s_data_insert = '0;
    bus.s_keep_insert = '0;     bus.s_byte_insert_cnt = '0;
    bus.ready_in = 1'b0;        bus.ready_insert = 1'b0;
  endtask

  task automatic set_fixed_hdrs();
    bus.s_data_insert     = {32'h5A5A5A5A, 32'hA5A5A5A5};
    bus.s_keep_insert     = {4'hF, 4'h7};
    bus.s_byte_insert_cnt = {2'd3, 2'd2};
    bus.s_keep_in         = {4'h3, 4'hF};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'(ctrl()), 64'(0));
    chk("reset_data_in", 64'(bus.data_in), 64'(0));
    chk("reset_hdr_out", 64'({bus.data_insert, bus.keep_insert, bus.byte_insert_cnt}), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  v_ins, v_in, last;
    logic [31:0] pdat;
    logic        rin, rins;
    logic [9:0]  ectrl;
    logic [31:0] doin, doins;
    logic [5:0]  kc;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v_ins, logic [1:0] v_in, logic [1:0] last,
                              logic [31:0] pdat, logic rin, logic rins, logic [9:0] ectrl,
                              logic [31:0] doin, logic [31:0] doins, logic [5:0] kc);
    vec_t v;
    v.v_ins = v_ins; v.v_in = v_in; v.last = last; v.pdat = pdat; v.rin = rin; v.rins = rins;
    v.ectrl = ectrl; v.doin = doin; v.doins = doins; v.kc = kc;
    return v;
  endfunction

  // Random-traffic storage and model state.
  int          npk [N];
  logic [31:0] hd  [N][MAXP];
  logic [3:0]  hk  [N][MAXP];
  logic [1:0]  hc  [N][MAXP];
  int          ln  [N][MAXP];
  logic [31:0] bd  [N][MAXP][MAXL];
  logic [3:0]  bk  [N][MAXP][MAXL];
  int          ord [$];

  task automatic random_round(input int round);
    int rem [N];
    int hsent [N], ppk [N], pbt [N], hrecv [N];
    logic vin_on [N];
    int ptr, opos, cur_r, cur_p, cur_b, cyc;
    logic open, stall_prev, stall_last, idle_chk;
    logic [31:0] stall_dat;

    ord.delete();
    for (int i = 0; i < N; i++) begin
      npk[i] = $urandom_range(1, MAXP);
      for (int p = 0; p < MAXP; p++) begin
        hd[i][p] = $urandom; hk[i][p] = 4'($urandom); hc[i][p] = 2'($urandom);
        ln[i][p] = $urandom_range(1, MAXL);
        for (int b = 0; b < MAXL; b++) begin
          bd[i][p][b] = $urandom; bk[i][p][b] = 4'($urandom);
        end
      end
      rem[i] = npk[i]; hsent[i] = 0; ppk[i] = 0; pbt[i] = 0; hrecv[i] = 0; vin_on[i] = 1'b0;
    end
    // Packet-level model: everyone with packets left keeps requesting, so grants
    // follow plain round-robin over the remaining counts.
    ptr = 0;
    for (int t = 0; t < N * MAXP; t++) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr + k) % N;
        if (rem[i] > 0) begin
          ord.push_back(i);
          rem[i]--;
          ptr = (i + 1) % N;
          break;
        end
      end
    end

    opos = 0; open = 1'b0; cur_r = 0; cur_p = 0; cur_b = 0;
    stall_prev = 1'b0; stall_last = 1'b0; stall_dat = '0; idle_chk = 1'b0;
    cyc = 0;
    while (cyc < 4000 && !(opos == ord.size() && !open)) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hsent[i] < npk[i]) begin
          bus.s_valid_insert[i] = 1'b1;
          bus.s_data_insert[i*DW +: DW]     = hd[i][hsent[i]];
          bus.s_keep_insert[i*KW +: KW]     = hk[i][hsent[i]];
          bus.s_byte_insert_cnt[i*CW +: CW] = hc[i][hsent[i]];
        end else begin
          bus.s_valid_insert[i] = 1'b0;
        end
        if (ppk[i] < npk[i]) begin
          if (!vin_on[i]) vin_on[i] = ($urandom_range(0, 3) != 0);
          bus.s_valid_in[i]         = vin_on[i];
          bus.s_data_in[i*DW +: DW] = bd[i][ppk[i]][pbt[i]];
          bus.s_keep_in[i*KW +: KW] = bk[i][ppk[i]][pbt[i]];
          bus.s_last_in[i]          = (pbt[i] == ln[i][ppk[i]] - 1);
        end else begin
          bus.s_valid_in[i] = 1'b0;
        end
      end
      bus.ready_in     = (cyc % 7 != 6) && ($urandom_range(0, 4) != 0);
      bus.ready_insert = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (stall_prev)
        chk("stall_hold", 64'({bus.valid_in, bus.last_in, bus.data_in}),
            64'({1'b1, stall_last, stall_dat}));
      if (idle_chk) chk("idle_gap", 64'(bus.busy), 64'(0));
      idle_chk = 1'b0;
      if (bus.valid_insert && bus.ready_insert) begin
        chk("hdr_while_open", 64'(open), 64'(0));
        if (opos < ord.size()) begin
          cur_r = ord[opos];
          cur_p = hrecv[cur_r];
          chk("hdr_gnt", 64'(bus.gnt_id), 64'(cur_r));
          chk("hdr_fields", 64'({bus.data_insert, bus.keep_insert, bus.byte_insert_cnt}),
              64'({hd[cur_r][cur_p], hk[cur_r][cur_p], hc[cur_r][cur_p]}));
          hrecv[cur_r]++;
          opos++;
          open = 1'b1;
          cur_b = 0;
        end else begin
          chk("hdr_extra", 64'(opos + 1), 64'(ord.size()));
        end
      end
      if (bus.valid_in && bus.ready_in) begin
        chk("beat_in_packet", 64'(open), 64'(1));
        if (open) begin
          chk("beat", 64'({bus.gnt_id, bus.last_in, bus.len_err, bus.keep_in, bus.data_in}),
              64'({GW'(cur_r), cur_b == ln[cur_r][cur_p] - 1, 1'b0,
                   bk[cur_r][cur_p][cur_b], bd[cur_r][cur_p][cur_b]}));
          cur_b++;
          if (cur_b == ln[cur_r][cur_p]) begin
            open = 1'b0;
            idle_chk = 1'b1;
          end
        end
      end
      stall_prev = bus.valid_in && !bus.ready_in;
      stall_dat  = bus.data_in;
      stall_last = bus.last_in;
      for (int i = 0; i < N; i++) begin
        if (bus.s_valid_insert[i] && bus.s_ready_insert[i]) hsent[i]++;
        if (bus.s_valid_in[i] && bus.s_ready_in[i]) begin
          vin_on[i] = 1'b0;
          pbt[i]++;
          if (pbt[i] == ln[i][ppk[i]]) begin
            ppk[i]++;
            pbt[i] = 0;
          end
        end
      end
      cyc++;
    end
    chk($sformatf("round%0d_done", round), 64'({opos, open}), 64'({ord.size(), 1'b0}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [$];
    int b, pulses, pbeat;
    logic hdr_done, done, seen;

    zero_inputs();
    do_reset();

    // Single packet from req 0, then contention with rr_ptr at 1 and header stall.
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h0,        1, 1, 10'b0_0_0_0_0_00_00_0, 32'h0,        32'h0,        6'h00));
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h0,        1, 1, 10'b1_0_1_0_0_01_00_0, 32'h0,        32'hA5A5A5A5, {4'h7, 2'd2}));
    tv.push_back(mk(2'b00, 2'b01, 2'b00, 32'h11111111, 1, 1, 10'b1_0_0_1_0_00_01_0, 32'h11111111, 32'h0,        6'h00));
    tv.push_back(mk(2'b00, 2'b01, 2'b00, 32'h22222222, 1, 1, 10'b1_0_0_1_0_00_01_0, 32'h22222222, 32'h0,        6'h00));
    tv.push_back(mk(2'b00, 2'b01, 2'b01, 32'h33333333, 1, 1, 10'b1_0_0_1_1_00_01_0, 32'h33333333, 32'h0,        6'h00));
    tv.push_back(mk(2'b11, 2'b00, 2'b00, 32'h0,        1, 0, 10'b0_0_0_0_0_00_00_0, 32'h0,        32'h0,        6'h00));
    for (int r = 0; r < 3; r++)
      tv.push_back(mk(2'b11, 2'b00, 2'b00, 32'h0,      1, 0, 10'b1_1_1_0_0_00_00_0, 32'h0,        32'h5A5A5A5A, {4'hF, 2'd3}));
    tv.push_back(mk(2'b11, 2'b00, 2'b00, 32'h0,        1, 1, 10'b1_1_1_0_0_10_00_0, 32'h0,        32'h5A5A5A5A, {4'hF, 2'd3}));
    tv.push_back(mk(2'b01, 2'b11, 2'b11, 32'h44444444, 0, 1, 10'b1_1_0_1_1_00_00_0, 32'hBBBBBBBB, 32'h0,        6'h00));
    tv.push_back(mk(2'b01, 2'b11, 2'b11, 32'h44444444, 1, 1, 10'b1_1_0_1_1_00_10_0, 32'hBBBBBBBB, 32'h0,        6'h00));
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h0,        1, 0, 10'b0_1_0_0_0_00_00_0, 32'h0,        32'h0,        6'h00));
    tv.push_back(mk(2'b01, 2'b00, 2'b00, 32'h0,        1, 0, 10'b1_0_1_0_0_00_00_0, 32'h0,        32'hA5A5A5A5, {4'h7, 2'd2}));

    set_fixed_hdrs();
    for (int r = 0; r < tv.size(); r++) begin
      @(posedge clk); #1;
      bus.s_valid_insert = tv[r].v_ins;
      bus.s_valid_in     = tv[r].v_in;
      bus.s_last_in      = tv[r].last;
      bus.s_data_in      = {~tv[r].pdat, tv[r].pdat};
      bus.ready_in       = tv[r].rin;
      bus.ready_insert   = tv[r].rins;
      @(negedge clk);
      chk($sformatf("vec%0d_ctrl", r), 64'(ctrl()), 64'(tv[r].ectrl));
      chk($sformatf("vec%0d_data_in", r), 64'(bus.data_in), 64'(tv[r].doin));
      chk($sformatf("vec%0d_data_insert", r), 64'(bus.data_insert), 64'(tv[r].doins));
      chk($sformatf("vec%0d_keep_cnt", r), 64'({bus.keep_insert, bus.byte_insert_cnt}), 64'(tv[r].kc));
    end

    // 64-beat packet: len_err exactly once, on the 64th beat, and the packet still ends.
    do_reset();
    set_fixed_hdrs();
    bus.ready_in = 1'b1; bus.ready_insert = 1'b1;
    hdr_done = 1'b0; done = 1'b0; b = 0; pulses = 0; pbeat = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      bus.s_valid_insert = hdr_done ? 2'b00 : 2'b01;
      bus.s_valid_in     = 2'b01;
      bus.s_data_in      = {32'h0, 32'(b)};
      bus.s_last_in      = {1'b0, b == MB - 1};
      @(negedge clk);
      if (bus.len_err) begin
        pulses += (bus.valid_in && bus.ready_in) ? 1 : 10;
        pbeat = b + 1;
      end
      if (bus.valid_insert && bus.ready_insert) hdr_done = 1'b1;
      if (bus.valid_in && bus.ready_in) begin
        chk("long_beat_data", 64'(bus.data_in), 64'(b));
        if (bus.last_in) done = 1'b1;
        b++;
      end
    end
    chk("long_done", 64'(done), 64'(1));
    chk("long_beats", 64'(b), 64'(MB));
    chk("len_err_pulses", 64'(pulses), 64'(1));
    chk("len_err_beat", 64'(pbeat), 64'(MB));
    @(posedge clk); #1 zero_inputs();
    @(negedge clk);
    chk("long_idle", 64'(bus.busy), 64'(0));

    // Reset while req 1 holds the engine mid-payload.
    set_fixed_hdrs();
    bus.s_valid_insert = 2'b10; bus.s_valid_in = 2'b10; bus.s_data_in = {32'hCAFEF00D, 32'h0};
    bus.ready_insert = 1'b1; bus.ready_in = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.valid_in;
    end
    chk("pre_reset_body", 64'({seen, bus.gnt_id, bus.busy}), 64'({1'b1, 1'b1, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 64'(ctrl()), 64'(0));
    chk("arst_data_in", 64'(bus.data_in), 64'(0));
    chk("arst_hdr_out", 64'(bus.data_insert), 64'(0));
    zero_inputs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_state", 64'({bus.busy, bus.gnt_id}), 64'(0));

    for (int r = 0; r < 3; r++) begin
      do_reset();
      random_round(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
